// File: rtl/input_packer_pkg.sv
// input_packer_pkg: shared widths and FSM encoding for the input packer
package input_packer_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_DATA = 8;
  localparam int BEAT_WIDTH = DATA_WIDTH * NUM_DATA;
  localparam int CNT_WIDTH = 16;
  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/input_packer_out_reg.sv
// packer_out_reg: holds one finished beat, issues the push strobe and counts pushed beats
module packer_out_reg import input_packer_pkg::*; #(
  parameter int BW = BEAT_WIDTH,
  parameter int CW = CNT_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wrt_en,
  input  logic          full_in,
  input  logic          load,
  input  logic [BW-1:0] load_data,
  output logic          push_out,
  output logic          out_valid,
  output logic [BW-1:0] data_out,
  output logic [CW-1:0] beat_count
);
  assign push_out = out_valid && !full_in && wrt_en;
  // a load in the same cycle as a pop keeps out_valid high so beats follow back to back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      out_valid <= 1'b0;
      beat_count <= '0;
    end else begin
      if (load) data_out <= load_data;
      out_valid <= load || (out_valid && !push_out);
      if (push_out) beat_count <= beat_count + CW'(1);
    end
  end
endmodule

// File: rtl/input_packer.sv
// input_packer: gathers words into zero-padded multi-lane beats for the downstream FIFO
module input_packer import input_packer_pkg::*; #(
  parameter int DATA_WIDTH = input_packer_pkg::DATA_WIDTH,
  parameter int NUM_DATA = input_packer_pkg::NUM_DATA,
  parameter int CNT_WIDTH = input_packer_pkg::CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wrt_en,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           in_last,
  output logic                           in_ready,
  input  logic                           full_in,
  output logic                           push_out,
  output logic [DATA_WIDTH*NUM_DATA-1:0] data_out,
  output logic [CNT_WIDTH-1:0]           beat_count,
  output logic                           busy
);
  localparam int BW = DATA_WIDTH * NUM_DATA;
  localparam int IW = NUM_DATA > 1 ? $clog2(NUM_DATA) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DATA - 1);
  state_t state, state_nx;
  logic [BW-1:0] acc, acc_wr;
  logic [IW-1:0] idx;
  logic accept, complete, load, out_valid;
  assign accept = in_valid && in_ready;
  assign complete = accept && (in_last || idx == LAST);
  assign load = wrt_en && (complete || state == FULL) && (!out_valid || push_out);
  // accumulator view including the word arriving this cycle
  always_comb begin
    acc_wr = acc;
    if (accept) acc_wr[idx*DATA_WIDTH +: DATA_WIDTH] = in_data;
  end
  // lane storage; clearing on every transfer is what zero-pads short frames
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      idx <= '0;
    end else begin
      acc <= load ? '0 : acc_wr;
      idx <= complete ? '0 : accept ? idx + IW'(1) : idx;
    end
  end
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else state <= state_nx;
  end
  // FULL parks a completed beat until the output register frees up
  always_comb begin
    state_nx = state == FILL ? (complete && !load ? FULL : FILL) : (load ? FILL : FULL);
  end
  // handshake and activity outputs
  always_comb begin
    in_ready = reset && wrt_en && state == FILL;
    busy = out_valid || idx != '0 || state == FULL;
  end
  packer_out_reg #(.BW(BW), .CW(CNT_WIDTH)) u_out (
    .clk(clk),
    .reset(reset),
    .wrt_en(wrt_en),
    .full_in(full_in),
    .load(load),
    .load_data(acc_wr),
    .push_out(push_out),
    .out_valid(out_valid),
    .data_out(data_out),
    .beat_count(beat_count)
  );
endmodule

// File: tb/tb_input_packer.sv
// tb_input_packer: random and directed stimulus against a beat-queue reference model
module tb_input_packer;
  localparam int DW = 32;
  localparam int N = 8;
  localparam int BW = DW * N;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic wrt_en = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic full_in = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, push_out, busy;
  logic [BW-1:0] data_out;
  logic [CW-1:0] beat_count;
  int checks = 0;
  int failures = 0;
  logic [BW-1:0] q[$];
  logic [DW-1:0] cur[$];
  logic [BW-1:0] last_out = '0;
  int pushes = 0;
  input_packer dut (
    .clk(clk), .reset(reset), .wrt_en(wrt_en), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .full_in(full_in), .push_out(push_out),
    .data_out(data_out), .beat_count(beat_count), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [BW-1:0] got, logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    cur.delete();
    last_out = '0;
    pushes = 0;
  endtask
  task automatic step();
    logic ei, ep;
    logic [BW-1:0] ed, b;
    ep = q.size() > 0 && !full_in && wrt_en;
    ei = wrt_en && q.size() < 2;
    ed = q.size() > 0 ? q[0] : last_out;
    @(negedge clk);
    check("in_ready", in_ready, ei);
    check("push_out", push_out, ep);
    check("data_out", data_out, ed);
    check("busy", busy, q.size() > 0 || cur.size() > 0);
    check("beat_count", beat_count, CW'(pushes));
    @(posedge clk);
    if (ep) begin
      last_out = q.pop_front();
      pushes++;
    end
    if (ei && in_valid) begin
      cur.push_back(in_data);
      if (in_last || cur.size() == N) begin
        b = '0;
        foreach (cur[i]) b[i*DW +: DW] = cur[i];
        q.push_back(b);
        cur.delete();
      end
    end
    #1;
  endtask
  task automatic drive(logic v, logic [DW-1:0] d, logic l, logic f, logic w);
    in_valid = v;
    in_data = d;
    in_last = l;
    full_in = f;
    wrt_en = w;
    step();
  endtask
  task automatic check_reset_outputs(string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_push_out"}, push_out, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_count"}, beat_count, 0);
  endtask
  initial begin
    wrt_en = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hdead_beef;
    #12;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    for (int i = 1; i <= 16; i++) drive(1'b1, DW'(i), i == 16, 1'b0, 1'b1);
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("t1_count", beat_count, 2);
    check("t1_beat2", data_out, {32'h10, 32'hf, 32'he, 32'hd, 32'hc, 32'hb, 32'ha, 32'h9});
    drive(1'b1, 32'ha, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'hb, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'hc, 1'b1, 1'b0, 1'b1);
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("t2_count", beat_count, 3);
    check("t2_pad", data_out, {160'h0, 32'hc, 32'hb, 32'ha});
    for (int i = 0; i < 24; i++) drive(1'b1, DW'(32'h100 + i), 1'b0, 1'b1, 1'b1);
    check("t3_stall", in_ready, 0);
    check("t3_held", data_out, {32'h107, 32'h106, 32'h105, 32'h104, 32'h103, 32'h102, 32'h101, 32'h100});
    for (int i = 0; i < 10; i++) drive(1'b1, DW'(32'h200 + i), 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h2ff, 1'b1, 1'b0, 1'b1);
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) drive(1'b1, DW'(32'h300 + i), 1'b0, 1'b1, 1'b1);
    drive(1'b1, 32'h30f, 1'b0, 1'b0, 1'b1);
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(32'h400 + i), 1'b0, 1'b0, 1'b1);
    repeat (5) drive(1'b1, 32'h4ee, 1'b1, 1'b0, 1'b0);
    for (int i = 3; i < 8; i++) drive(1'b1, DW'(32'h400 + i), i == 7, 1'b0, 1'b1);
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 1000; i++)
        drive($urandom_range(99) < 70, $urandom, $urandom_range(99) < 10,
              $urandom_range(99) < (p * 40), $urandom_range(99) < 90);
    repeat (4) drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, DW'(32'h500 + i), 1'b0, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b1, DW'(32'h600 + i), 1'b0, 1'b0, 1'b1);
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("rst_clean", data_out, {32'h607, 32'h606, 32'h605, 32'h604, 32'h603, 32'h602, 32'h601, 32'h600});
    check("rst_count", beat_count, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/input_packer.md
Name: input_packer

Overview:
- Stage directly upstream of the compressor's input FIFO.
- Gathers a stream of 32-bit words into NUM_DATA-word beats and presents each beat as data_out with a one-cycle push_out strobe.
- Honours the downstream full flag, so no beat is lost or duplicated.
- Zero-pads short frames terminated by in_last, and counts beats pushed.

Parameters:
- DATA_WIDTH, 32, width of one input word / one lane
- NUM_DATA, 8, lanes per beat; beat width = DATA_WIDTH*NUM_DATA
- CNT_WIDTH, 16, width of beat_count

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- wrt_en  in  1  global advance enable; when 0 all state holds
- in_valid  in  1  upstream word valid
- in_data  in  DATA_WIDTH  upstream word
- in_last  in  1  marks final word of a frame; qualified by in_valid
- in_ready  out  1  block accepts in_data this cycle
- full_in  in  1  downstream FIFO full
- push_out  out  1  one-cycle push strobe to downstream FIFO
- data_out  out  DATA_WIDTH*NUM_DATA  beat; lane k at bits [DATA_WIDTH*k +: DATA_WIDTH]
- beat_count  out  CNT_WIDTH  number of beats pushed since reset, wraps
- busy  out  1  any word held in accumulator or output register

Behaviour:
- Storage:
  - accumulator acc (NUM_DATA lanes) with lane index idx (0..NUM_DATA-1)
  - output register out_reg with flag out_valid
- Reset (reset=0, asynchronous): acc=0, idx=0, out_reg=0, out_valid=0, beat_count=0, state=FILL. Outputs: in_ready=0, push_out=0, data_out=0, busy=0.
- Word acceptance:
  - Accept when in_valid && in_ready at a clock edge; word is written to lane idx.
  - First word of a beat goes to lane 0.
- State machine:
  - FILL, in_ready = wrt_en:
    - Accept with idx<NUM_DATA-1 and !in_last: idx++.
    - Accept with idx==NUM_DATA-1 or in_last: beat complete.
  - On beat complete:
    - If !out_valid, or out_reg pops this same cycle: acc->out_reg, out_valid=1, acc cleared to 0, idx=0, stay FILL.
    - Else go to FULL with acc held.
  - FULL, in_ready=0: when out_reg pops, or out_valid=0, acc->out_reg, clear acc, idx=0, go to FILL.
- Zero padding: unused lanes of a short frame are 0, guaranteed by clearing acc on every transfer.
- Output:
  - push_out = out_valid && !full_in && wrt_en (combinational).
  - Pop = push_out. On pop: out_valid=0 unless refilled in the same cycle, and beat_count increments modulo 2^CNT_WIDTH.
  - data_out = out_reg at all times; out_reg is held, never cleared, until the next load.
- Latency: word completing a beat accepted at edge N -> push_out high in cycle after N (if full_in=0). Sustained throughput is 1 word/cycle with no bubbles while full_in=0.
- Backpressure:
  - full_in=1 holds out_valid and data_out stable.
  - Filling continues until acc completes, then state goes to FULL and in_ready drops.
- Simultaneous events:
  - Pop and acc completion in the same cycle: both occur, new beat lands in out_reg with no gap.
  - in_last on lane NUM_DATA-1: one full beat, no extra empty beat.
- in_last with no pending words is impossible; in_last always accompanies a word.
- Empty frames are never produced.
- wrt_en=0: no state changes, in_ready=0, push_out=0.
- busy = out_valid || idx!=0 || state==FULL.
- Reset mid-operation: partial beat and out_reg are discarded; no push_out is issued for them.

Decomposition:
- Shared package holds: DATA_WIDTH, NUM_DATA, beat width constant, state encoding (FILL, FULL).
- One natural sub-module: packer_out_reg (out_reg, out_valid, pop logic, beat_count), instantiated once.
- Accumulator and FSM stay in the top.

Test Plan:
- 16 consecutive words 0x1..0x10, in_last on 0x10, full_in=0 -> two pushes: lanes 0x1..0x8, then 0x9..0x10. Pushes one cycle after words 8 and 16. beat_count=2.
- 3 words 0xA,0xB,0xC with last on 0xC -> single push: lane0..2 = A,B,C, lanes 3..7 = 0. beat_count=1.
- full_in=1 held, 24 words offered -> exactly 16 accepted, in_ready=0 afterwards, data_out stable, no push. Release full_in -> pushes on consecutive cycles and accepting resumes.
- full_in deasserts on the same edge that the 8th word of the next beat arrives -> push of old beat and load of new beat with no idle cycle. No word lost or duplicated (scoreboard).
- wrt_en dropped for 5 cycles mid-beat -> in_ready=0, push_out=0, idx and beat_count unchanged. Stream resumes correctly.
- reset pulsed low asynchronously after 5 words -> outputs 0 immediately. Next 8 words after release form a clean beat with no residue from before reset.
